// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS core: sequences fetch/decode/execute
// and drives every datapath mux select and write enable from the current state.
module multicycle_controller #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [2:0] AluCtl,
  output logic       ExtOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB = 4'd7,
    BRANCH = 4'd8,  IEXEC  = 4'd9,  IWB    = 4'd10, JUMP  = 4'd11,
    HALT   = 4'd12
  } state_t;

  typedef enum logic [1:0] {I_ADD, I_SLT, I_AND, I_OR} iop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW   = 6'b100011, OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000, OP_ANDI = 6'b001100, OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001, ALU_SLT = 3'b111;

  state_t state, nextState;
  logic   isSw, isBne;
  iop_t   iOp;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= nextState;
  end

  // Op may change once the instruction register reloads, so capture what later states need.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      isSw  <= 1'b0;
      isBne <= 1'b0;
      iOp   <= I_ADD;
    end else if (state == DECODE) begin
      isSw  <= (Op == OP_SW);
      isBne <= (Op == OP_BNE);
      case (Op)
        OP_SLTI: iOp <= I_SLT;
        OP_ANDI: iOp <= I_AND;
        OP_ORI:  iOp <= I_OR;
        default: iOp <= I_ADD;
      endcase
    end
  end

  always_comb begin
    nextState = FETCH;
    case (state)
      FETCH:  nextState = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW:                      nextState = MEMADR;
          OP_RTYPE:                          nextState = EXEC;
          OP_BEQ, OP_BNE:                    nextState = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nextState = IEXEC;
          OP_J:                              nextState = JUMP;
          default:                           nextState = ILLEGAL_TRAP ? HALT : FETCH;
        endcase
      end
      MEMADR: nextState = isSw ? MEMWR : MEMRD;
      MEMRD:  nextState = MEMWB;
      EXEC:   nextState = ALUWB;
      IEXEC:  nextState = IWB;
      HALT:   nextState = HALT;
      default: nextState = FETCH;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    AluSrcA  = 1'b0;
    AluSrcB  = 2'b00;
    AluCtl   = ALU_ADD;
    ExtOp    = 1'b0;
    PCSrc    = 2'b00;
    PCEn     = 1'b0;
    Illegal  = 1'b0;
    case (state)
      FETCH: begin
        IRWrite = 1'b1;
        AluSrcB = 2'b01;
        PCEn    = 1'b1;
      end
      DECODE: begin
        AluSrcB = 2'b11;
        ExtOp   = 1'b1;
      end
      MEMADR: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        ExtOp   = 1'b1;
      end
      MEMRD: IorD = 1'b1;
      MEMWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXEC: begin
        AluSrcA = 1'b1;
        case (Funct)
          6'b100010: AluCtl = ALU_SUB;
          6'b100100: AluCtl = ALU_AND;
          6'b100101: AluCtl = ALU_OR;
          6'b101010: AluCtl = ALU_SLT;
          default:   AluCtl = ALU_ADD;
        endcase
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        AluSrcA = 1'b1;
        AluCtl  = ALU_SUB;
        PCSrc   = 2'b01;
        PCEn    = isBne ? ~Zero : Zero;
      end
      IEXEC: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        case (iOp)
          I_SLT: begin AluCtl = ALU_SLT; ExtOp = 1'b1; end
          I_AND: AluCtl = ALU_AND;
          I_OR:  AluCtl = ALU_OR;
          default: begin AluCtl = ALU_ADD; ExtOp = 1'b1; end
        endcase
      end
      IWB:  RegWrite = 1'b1;
      JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      HALT: Illegal = 1'b1;
      default: ;
    endcase
    // Reset holds the FSM in FETCH; suppress its enables until reset releases.
    if (!reset_n) begin
      PCEn     = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign State = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed latency table, hand-written corner
// sequences, and a random instruction stream against a per-instruction trace model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Zero = 1'b0;
  // {IorD,MemWrite,IRWrite,RegDst,MemToReg,RegWrite,AluSrcA,AluSrcB,AluCtl,ExtOp,PCSrc,PCEn,Illegal,State}
  wire [20:0] o0, o1;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.ILLEGAL_TRAP(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(o0[20]), .MemWrite(o0[19]), .IRWrite(o0[18]), .RegDst(o0[17]),
    .MemToReg(o0[16]), .RegWrite(o0[15]), .AluSrcA(o0[14]), .AluSrcB(o0[13:12]),
    .AluCtl(o0[11:9]), .ExtOp(o0[8]), .PCSrc(o0[7:6]), .PCEn(o0[5]),
    .Illegal(o0[4]), .State(o0[3:0])
  );

  multicycle_controller #(.ILLEGAL_TRAP(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(o1[20]), .MemWrite(o1[19]), .IRWrite(o1[18]), .RegDst(o1[17]),
    .MemToReg(o1[16]), .RegWrite(o1[15]), .AluSrcA(o1[14]), .AluSrcB(o1[13:12]),
    .AluCtl(o1[11:9]), .ExtOp(o1[8]), .PCSrc(o1[7:6]), .PCEn(o1[5]),
    .Illegal(o1[4]), .State(o1[3:0])
  );

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0c, OP_ORI = 6'h0d;
  localparam logic [5:0] OP_SLTI = 6'h0a, OP_J = 6'h02, OP_BAD = 6'h3f;
  localparam int A_ADD = 2, A_SUB = 6, A_AND = 0, A_OR = 1, A_SLT = 7;
  localparam int SB_B = 0, SB_4 = 1, SB_IMM = 2, SB_IMM2 = 3;

  function automatic logic [20:0] ctl(input int st, iord, memw, irw, regdst, m2r, regw,
                                      srca, srcb, alu, ext, pcsrc, pcen, ill);
    return {1'(iord), 1'(memw), 1'(irw), 1'(regdst), 1'(m2r), 1'(regw), 1'(srca),
            2'(srcb), 3'(alu), 1'(ext), 2'(pcsrc), 1'(pcen), 1'(ill), 4'(st)};
  endfunction

  function automatic int aluOfFunct(input logic [5:0] f);
    case (f)
      6'h22:   return A_SUB;
      6'h24:   return A_AND;
      6'h25:   return A_OR;
      6'h2a:   return A_SLT;
      default: return A_ADD;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Trace model: each instruction expands into its list of per-cycle expected outputs.
  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [20:0] exp;
  } cyc_t;
  cyc_t trace[$];

  function automatic void pushCyc(input logic [5:0] o, f, input logic z, input logic [20:0] e);
    cyc_t c;
    c.op = o; c.funct = f; c.zero = z; c.exp = e;
    trace.push_back(c);
  endfunction

  function automatic void buildInstr(input logic [5:0] op, funct);
    logic z;
    pushCyc(op, funct, 1'($urandom), ctl(0, 0, 0, 1, 0, 0, 0, 0, SB_4, A_ADD, 0, 0, 1, 0));
    pushCyc(op, funct, 1'($urandom), ctl(1, 0, 0, 0, 0, 0, 0, 0, SB_IMM2, A_ADD, 1, 0, 0, 0));
    // From here on Op is scrambled: the instruction must already be decided.
    case (op)
      OP_LW: begin
        pushCyc(6'($urandom), funct, 1'($urandom), ctl(2, 0, 0, 0, 0, 0, 0, 1, SB_IMM, A_ADD, 1, 0, 0, 0));
        pushCyc(6'($urandom), funct, 1'($urandom), ctl(3, 1, 0, 0, 0, 0, 0, 0, SB_B, A_ADD, 0, 0, 0, 0));
        pushCyc(6'($urandom), funct, 1'($urandom), ctl(4, 0, 0, 0, 0, 1, 1, 0, SB_B, A_ADD, 0, 0, 0, 0));
      end
      OP_SW: begin
        pushCyc(6'($urandom), funct, 1'($urandom), ctl(2, 0, 0, 0, 0, 0, 0, 1, SB_IMM, A_ADD, 1, 0, 0, 0));
        pushCyc(6'($urandom), funct, 1'($urandom), ctl(5, 1, 1, 0, 0, 0, 0, 0, SB_B, A_ADD, 0, 0, 0, 0));
      end
      OP_R: begin
        pushCyc(6'($urandom), funct, 1'($urandom), ctl(6, 0, 0, 0, 0, 0, 0, 1, SB_B, aluOfFunct(funct), 0, 0, 0, 0));
        pushCyc(6'($urandom), funct, 1'($urandom), ctl(7, 0, 0, 0, 1, 0, 1, 0, SB_B, A_ADD, 0, 0, 0, 0));
      end
      OP_BEQ, OP_BNE: begin
        z = 1'($urandom);
        pushCyc(6'($urandom), funct, z, ctl(8, 0, 0, 0, 0, 0, 0, 1, SB_B, A_SUB, 0, 1,
                                           int'((op == OP_BNE) ? !z : z), 0));
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        pushCyc(6'($urandom), funct, 1'($urandom), ctl(9, 0, 0, 0, 0, 0, 0, 1, SB_IMM,
                (op == OP_ADDI) ? A_ADD : (op == OP_SLTI) ? A_SLT : (op == OP_ANDI) ? A_AND : A_OR,
                int'(op == OP_ADDI || op == OP_SLTI), 0, 0, 0));
        pushCyc(6'($urandom), funct, 1'($urandom), ctl(10, 0, 0, 0, 0, 0, 1, 0, SB_B, A_ADD, 0, 0, 0, 0));
      end
      OP_J:
        pushCyc(6'($urandom), funct, 1'($urandom), ctl(11, 0, 0, 0, 0, 0, 0, 0, SB_B, A_ADD, 0, 2, 1, 0));
      default: ;
    endcase
  endfunction

  // Runs one instruction from FETCH back to FETCH, tallying cycles and enable pulses.
  task automatic runInstr(input logic [5:0] op, funct, input logic z,
                          output int lat, rw, mw, pe, output logic [2:0] alu3);
    Op = op; Funct = funct; Zero = z;
    lat = 0; rw = 0; mw = 0; pe = 0; alu3 = 3'b000;
    do begin
      @(negedge clk);
      lat++;
      rw += int'(o0[15]);
      mw += int'(o0[19]);
      pe += int'(o0[5]);
      if (lat == 3) alu3 = o0[11:9];
      @(posedge clk); #1;
    end while (o0[3:0] != 4'd0 && lat < 20);
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         lat, regW, memW, pcEn;
    logic [2:0] alu3;
  } vec_t;
  vec_t vecs[18];

  logic [20:0] fetchV, fetchRstV, decodeV, haltV;
  logic [5:0]  opList[11];
  logic [5:0]  fnList[5];
  int          lat, rw, mw, pe;
  logic [2:0]  alu3;
  int          lwStates[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{OP_LW,   6'h00, 1'b0, 5, 1, 0, 1, 3'b010};
    vecs[1]  = '{OP_SW,   6'h00, 1'b0, 4, 0, 1, 1, 3'b010};
    vecs[2]  = '{OP_R,    6'h20, 1'b1, 4, 1, 0, 1, 3'b010};
    vecs[3]  = '{OP_R,    6'h22, 1'b0, 4, 1, 0, 1, 3'b110};
    vecs[4]  = '{OP_R,    6'h24, 1'b0, 4, 1, 0, 1, 3'b000};
    vecs[5]  = '{OP_R,    6'h25, 1'b0, 4, 1, 0, 1, 3'b001};
    vecs[6]  = '{OP_R,    6'h2a, 1'b0, 4, 1, 0, 1, 3'b111};
    vecs[7]  = '{OP_R,    6'h3f, 1'b0, 4, 1, 0, 1, 3'b010};
    vecs[8]  = '{OP_BEQ,  6'h00, 1'b1, 3, 0, 0, 2, 3'b110};
    vecs[9]  = '{OP_BEQ,  6'h00, 1'b0, 3, 0, 0, 1, 3'b110};
    vecs[10] = '{OP_BNE,  6'h00, 1'b0, 3, 0, 0, 2, 3'b110};
    vecs[11] = '{OP_BNE,  6'h00, 1'b1, 3, 0, 0, 1, 3'b110};
    vecs[12] = '{OP_ADDI, 6'h00, 1'b0, 4, 1, 0, 1, 3'b010};
    vecs[13] = '{OP_ANDI, 6'h00, 1'b0, 4, 1, 0, 1, 3'b000};
    vecs[14] = '{OP_ORI,  6'h00, 1'b0, 4, 1, 0, 1, 3'b001};
    vecs[15] = '{OP_SLTI, 6'h00, 1'b0, 4, 1, 0, 1, 3'b111};
    vecs[16] = '{OP_J,    6'h00, 1'b0, 3, 0, 0, 2, 3'b010};
    vecs[17] = '{OP_BAD,  6'h00, 1'b0, 2, 0, 0, 1, 3'b010};
    opList = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J, OP_BAD};
    fnList = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    lwStates = '{0, 1, 2, 3, 4};
    fetchV    = ctl(0, 0, 0, 1, 0, 0, 0, 0, SB_4, A_ADD, 0, 0, 1, 0);
    fetchRstV = ctl(0, 0, 0, 0, 0, 0, 0, 0, SB_4, A_ADD, 0, 0, 0, 0);
    decodeV   = ctl(1, 0, 0, 0, 0, 0, 0, 0, SB_IMM2, A_ADD, 1, 0, 0, 0);
    haltV     = ctl(12, 0, 0, 0, 0, 0, 0, 0, SB_B, A_ADD, 0, 0, 0, 1);

    // Reset: FETCH outputs with write enables suppressed.
    #1;
    check("reset_outputs_dut0", 32'(o0), 32'(fetchRstV));
    check("reset_outputs_dut1", 32'(o1), 32'(fetchRstV));
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // lw straight out of reset: state walk and pulse placement.
    Op = OP_LW; Funct = 6'h00; Zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("lw_cycle%0d {RegWrite,MemToReg,PCEn,State}", i + 1),
            32'({o0[15], o0[16], o0[5], o0[3:0]}),
            32'({i == 4, i == 4, i == 0, 4'(lwStates[i])}));
      @(posedge clk); #1;
    end
    check("lw_returns_fetch", 32'(o0[3:0]), 32'd0);

    // Directed latency / pulse-count table.
    for (int i = 0; i < 18; i++) begin
      runInstr(vecs[i].op, vecs[i].funct, vecs[i].zero, lat, rw, mw, pe, alu3);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_regwrite_pulses", i), rw, vecs[i].regW);
      check($sformatf("vec%0d_memwrite_pulses", i), mw, vecs[i].memW);
      check($sformatf("vec%0d_pcen_pulses", i), pe, vecs[i].pcEn);
      if (vecs[i].lat >= 3) check($sformatf("vec%0d_aluctl_cycle3", i), 32'(alu3), 32'(vecs[i].alu3));
    end

    // Random instruction stream against the trace model.
    for (int n = 0; n < 160; n++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : opList[$urandom_range(0, 10)];
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fnList[$urandom_range(0, 4)];
      buildInstr(op, fn);
    end
    foreach (trace[i]) begin
      Op = trace[i].op; Funct = trace[i].funct; Zero = trace[i].zero;
      @(negedge clk);
      check($sformatf("trace%0d", i), 32'(o0), 32'(trace[i].exp));
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of a store.
    Op = OP_SW; Funct = 6'h00; Zero = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("sw_in_memwr {MemWrite,State}", 32'({o0[19], o0[3:0]}), 32'({1'b1, 4'd5}));
    #2 reset_n = 1'b0;
    #1 check("async_reset_mid_memwr", 32'(o0), 32'(fetchRstV));
    @(posedge clk); #1;
    check("reset_held_across_edge", 32'(o0), 32'(fetchRstV));
    #1 reset_n = 1'b1;
    #1 check("fetch_after_release", 32'(o0), 32'(fetchV));

    // Illegal opcode: trap variant halts, default variant treats it as a nop.
    @(posedge clk); #1 reset_n = 1'b0;
    #1 check("trap_dut_reset", 32'(o1), 32'(fetchRstV));
    @(posedge clk); #1 reset_n = 1'b1;
    Op = OP_BAD;
    @(negedge clk);
    check("trap_fetch", 32'(o1), 32'(fetchV));
    @(posedge clk); #1;
    @(negedge clk);
    check("trap_decode", 32'(o1), 32'(decodeV));
    @(posedge clk); #1;
    check("nop_back_to_fetch", 32'(o0[3:0]), 32'd0);
    for (int i = 0; i < 20; i++) begin
      Op = 6'($urandom); Funct = 6'($urandom); Zero = 1'($urandom);
      @(negedge clk);
      check($sformatf("halt_cycle%0d", i), 32'(o1), 32'(haltV));
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1 check("halt_cleared_by_reset", 32'(o1), 32'(fetchRstV));
    @(posedge clk); #1 reset_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
